mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, 16: max bus-busy cycles before a transaction is aborted; range 2..255.
REQ-002 Parameter MAX_DBURST, 4: max consecutive data grants while a fetch is pending.
REQ-003 Clocking: one clock, clk; reset is synchronous and active-high, named reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 if_req  in  1  instruction fetch request, held until if_ack or if_fault.
REQ-007 if_addr  in  32  fetch address.
REQ-008 if_rdata  out  32  fetched instruction.
REQ-009 if_ack  out  1  one-cycle fetch completion pulse.
REQ-010 if_fault  out  1  one-cycle fetch error pulse.
REQ-011 d_req  in  1  data load/store request, held with its attributes until d_ack or d_err.
REQ-012 d_we  in  1  store when 1, load when 0.
REQ-013 d_addr, d_wdata  in  32 each  data address, store data.
REQ-014 d_wmask  in  4  store byte mask.
REQ-015 d_rdata  out  32  load data.
REQ-016 d_ack, d_err  out  1 each  one-cycle data completion / error pulses.
REQ-017 d_stall  out  1  d_req & ~d_ack & ~d_err, combinational.
REQ-018 bus_req, bus_we  out  1 each  shared memory port request, write enable.
REQ-019 bus_addr, bus_wdata  out  32 each; bus_wmask  out  4.
REQ-020 bus_ack, bus_err, bus_rdata  in  1/1/32  memory completion, error, read data.

Function
REQ-021 FSM states IDLE, IF_BUSY, D_BUSY; all bus and response outputs are registered.
REQ-022 IDLE, d_req only: next state D_BUSY; latch d_we, d_addr, d_wdata, d_wmask onto bus_*; bus_req=1 from the next cycle.
REQ-023 IDLE, if_req only: next state IF_BUSY; bus_addr=if_addr, bus_we=0, bus_wmask=0.
REQ-024 IDLE, both requests: data wins unless burst counter == MAX_DBURST, in which case fetch wins.
REQ-025 Burst counter (8 bit): +1 on each data grant while if_req=1; cleared on fetch grant or any cycle with if_req=0; saturates at MAX_DBURST.
REQ-026 bus_req, bus_we, bus_addr, bus_wdata and bus_wmask stay constant while in a BUSY state.
REQ-027 In a BUSY state, bus_ack=1: bus_req=0 and the state returns to IDLE at the next edge; the owner's ack pulses that same next cycle (1-cycle registered latency).
REQ-028 Read completion: if_rdata/d_rdata capture bus_rdata on the bus_ack edge; on a write ack d_rdata keeps its previous value.
REQ-029 bus_err=1, or bus_ack=1 together with bus_err=1, in a BUSY state: treated as an error; the owner's if_fault/d_err pulses instead of the ack; bus_rdata is not captured.
REQ-030 Timeout counter: cleared on entering a BUSY state; +1 each BUSY cycle without ack/err.
REQ-031 Timeout: when the counter reaches TIMEOUT-1 with no ack/err, abort exactly like bus_err (bus_req=0, IDLE, error pulse).
REQ-032 bus_ack/bus_err in IDLE are ignored.
REQ-033 The arbiter spends at least one IDLE cycle between transactions; arbitration is re-evaluated in IDLE only.
REQ-034 A requester dropping its req mid-transaction does not cancel it; the response pulse is still issued.

Reset
REQ-035 reset=1 at an edge: state=IDLE; counters=0; every output register = 0 (bus_*, *_rdata, acks, errors).
REQ-036 Reset mid-transaction: bus_req=0 in the next cycle, and no ack/err pulse is issued for the aborted transaction.

Structure
REQ-037 A shared defines include holds the state encodings and the TIMEOUT/MAX_DBURST defaults for reuse by the core top level.
REQ-038 Single module, no sub-modules; the timeout and burst counters are inline.

Verification
REQ-039 Test 1: d_req load at addr 0x100; bus_ack with rdata 0xDEADBEEF 3 cycles after bus_req -> d_ack one cycle later, d_rdata=0xDEADBEEF, d_stall=1 until then.
REQ-040 Test 2: if_req and d_req held continuously, immediate acks -> exactly one fetch grant after every 4 data grants.
REQ-041 Test 3: store to 0x200, data 0x12345678, mask 0b0011 -> bus_we=1 with those values held until ack; d_rdata unchanged.
REQ-042 Test 4: no bus_ack for 16 busy cycles -> bus_req drops, d_err pulses once, FSM returns to IDLE.
REQ-043 Test 5: bus_ack and bus_err asserted in the same cycle during a fetch -> if_fault=1, if_ack=0.
REQ-044 Test 6: reset asserted 2 cycles into a fetch -> all outputs 0 the next cycle, no if_ack; a fresh fetch then completes normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and parameter defaults.
package mem_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIfBusy = 2'd1,
    StDBusy  = 2'd2
  } state_e;

  // Default bus-busy cycles before a transaction is aborted (legal range 2..255).
  localparam int unsigned TIMEOUT_DEFAULT    = 16;
  // Default number of back-to-back data grants allowed while a fetch waits.
  localparam int unsigned MAX_DBURST_DEFAULT = 4;

  // Width of the inline timeout and burst counters.
  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Shared memory-port bundle between the arbiter (master) and the memory (slave).
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wmask,
    input  bus_ack, bus_err, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wmask,
    output bus_ack, bus_err, bus_rdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto a single memory port.
// Data normally wins; a saturating burst counter forces a fetch grant after MAX_DBURST
// consecutive data grants. Each bus transaction is guarded by a timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT,
  parameter int unsigned MAX_DBURST = MAX_DBURST_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  // Instruction fetch port
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ack,
  output logic          if_fault,
  // Data port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [3:0]    d_wmask,
  output logic [31:0]   d_rdata,
  output logic          d_ack,
  output logic          d_err,
  output logic          d_stall,
  // Shared memory port
  mem_arbiter_if.master bus
);

  localparam logic [CNT_W-1:0] TmoLast  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BurstMax = CNT_W'(MAX_DBURST);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] burst_q, burst_d;

  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [3:0]       bus_wmask_q, bus_wmask_d;

  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      d_rdata_q, d_rdata_d;
  logic             if_ack_q, if_ack_d;
  logic             if_fault_q, if_fault_d;
  logic             d_ack_q, d_ack_d;
  logic             d_err_q, d_err_d;

  logic             resp_pending;
  logic             grant_d;
  logic             grant_if;
  logic             tmo_hit;
  logic             txn_done;
  logic             txn_fail;

  // While a response pulse is out, the requester still shows the request that just
  // completed; arbitrating then would reissue it, so that IDLE cycle never grants.
  assign resp_pending = if_ack_q | if_fault_q | d_ack_q | d_err_q;

  // Ack wins over an expiring timeout; ack together with err is an error.
  assign tmo_hit  = (tmo_q == TmoLast);
  assign txn_done = bus.bus_ack | bus.bus_err | tmo_hit;
  assign txn_fail = bus.bus_err | (~bus.bus_ack & tmo_hit);

  // Arbitration: data first unless the burst counter has saturated with a fetch waiting.
  always_comb begin
    grant_d  = 1'b0;
    grant_if = 1'b0;
    if (state_q == StIdle && !resp_pending) begin
      if (d_req && (!if_req || burst_q != BurstMax)) begin
        grant_d = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end
    end
  end

  // Burst counter: counts data grants that overtook a waiting fetch.
  always_comb begin
    burst_d = burst_q;
    if (!if_req || grant_if) begin
      burst_d = '0;
    end else if (grant_d && burst_q < BurstMax) begin
      burst_d = burst_q + CNT_W'(1);
    end
  end

  // FSM next state, bus port, response pulses and timeout counter.
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wmask_d = bus_wmask_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    if_fault_d  = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d     = StDBusy;
          tmo_d       = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = d_we;
          bus_addr_d  = d_addr;
          bus_wdata_d = d_wdata;
          bus_wmask_d = d_wmask;
        end else if (grant_if) begin
          state_d     = StIfBusy;
          tmo_d       = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_wdata_d = '0;
          bus_wmask_d = '0;
        end
      end

      StIfBusy: begin
        if (txn_done) begin
          state_d   = StIdle;
          bus_req_d = 1'b0;
          if (txn_fail) begin
            if_fault_d = 1'b1;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.bus_rdata;
          end
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end

      StDBusy: begin
        if (txn_done) begin
          state_d   = StIdle;
          bus_req_d = 1'b0;
          if (txn_fail) begin
            d_err_d = 1'b1;
          end else begin
            d_ack_d = 1'b1;
            // Stores leave the last load data visible.
            if (!bus_we_q) begin
              d_rdata_d = bus.bus_rdata;
            end
          end
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = StIdle;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous reset drops any transaction silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      tmo_q       <= '0;
      burst_q     <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wmask_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      if_fault_q  <= 1'b0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      burst_q     <= burst_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wmask_q <= bus_wmask_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      if_fault_q  <= if_fault_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_wmask = bus_wmask_q;

  assign if_rdata = if_rdata_q;
  assign if_ack   = if_ack_q;
  assign if_fault = if_fault_q;
  assign d_rdata  = d_rdata_q;
  assign d_ack    = d_ack_q;
  assign d_err    = d_err_q;

  assign d_stall  = d_req & ~d_ack_q & ~d_err_q;

  // Internal consistency: bus_req tracks the BUSY states and at most one pulse at a time.
  busy_req_a : assert property (@(posedge clk) disable iff (reset)
    (state_q != StIdle) == bus_req_q);
  one_pulse_a : assert property (@(posedge clk) disable iff (reset)
    $onehot0({if_ack_q, if_fault_q, d_ack_q, d_err_q}));
  burst_sat_a : assert property (@(posedge clk) disable iff (reset)
    burst_q <= BurstMax);

endmodule
